// File: rtl/otf_quotient_converter.sv
// otf_quotient_converter: on-the-fly conversion of an MSB-first radix-2
// signed-digit quotient into a two's-complement word using the Q/QM pair.
// Latency: result_valid is registered on the edge that accepts the last digit
// and rises in the cycle after it. Backpressure: the result is held in DONE
// until result_ack. There is no digit backpressure: digits outside ACCUM are
// dropped and flagged on digit_drop.
//
// Ports:
//   clk           rising-edge clock
//   asyn_reset    synchronous, active-high reset (priority over start)
//   start         clears Q/QM, counters and sticky flags; enters ACCUM
//   digit_in      signed digit: 2'b10=+1, 2'b01=-1, 2'b00=0, 2'b11=illegal (as 0)
//   digit_valid   digit_in is valid this cycle
//   result_ack    downstream has taken result (only acts in DONE)
//   result        UNROLLING+1 bit two's-complement quotient, MSB is the sign
//   result_valid  result is complete and stable
//   busy          high while in ACCUM
//   digit_cnt     digits accepted since the last start
//   digit_drop    sticky: a digit arrived outside ACCUM
//   digit_err     sticky: an illegal code was accepted
//
// Build option: define OTF_ERR_EN to enable digit_err reporting. When the macro
// is undefined, digit_err is tied low and 2'b11 is silently converted as 0.

module otf_quotient_converter #(
  parameter int UNROLLING = 64,
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 start,
  input  logic [1:0]           digit_in,
  input  logic                 digit_valid,
  input  logic                 result_ack,
  output logic [UNROLLING:0]   result,
  output logic                 result_valid,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] digit_cnt,
  output logic                 digit_drop,
  output logic                 digit_err
);

  localparam int W = UNROLLING + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(UNROLLING - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         q_q, q_d;
  logic [W-1:0]         qm_q, qm_d;
  logic [W-1:0]         result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic [CNT_WIDTH-1:0] digit_cnt_q, digit_cnt_d;
  logic                 digit_drop_q, digit_drop_d;

  // One step of the recurrence for the digit currently on digit_in.
  // Q always holds the converted value and QM holds Q-1, so a -1 digit
  // borrows by selecting QM instead of propagating a carry.
  logic [W-1:0] q_step, qm_step;

  always_comb begin
    q_step  = {q_q[W-2:0], 1'b0};
    qm_step = {qm_q[W-2:0], 1'b1};
    case (digit_in)
      2'b10: begin
        q_step  = {q_q[W-2:0], 1'b1};
        qm_step = {q_q[W-2:0], 1'b0};
      end
      2'b01: begin
        q_step  = {qm_q[W-2:0], 1'b1};
        qm_step = {qm_q[W-2:0], 1'b0};
      end
      default: begin
        // 2'b00 and the illegal 2'b11 both convert as a zero digit.
        q_step  = {q_q[W-2:0], 1'b0};
        qm_step = {qm_q[W-2:0], 1'b1};
      end
    endcase
  end

  // A digit is consumed only in ACCUM, and never in a start cycle.
  logic digit_accept;
  assign digit_accept = (state_q == ST_ACCUM) && digit_valid && !start;

  always_comb begin
    state_d        = state_q;
    q_d            = q_q;
    qm_d           = qm_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    digit_cnt_d    = digit_cnt_q;
    digit_drop_d   = digit_drop_q;

    if (start) begin
      // Restart from any state; a pending result is discarded and a digit
      // arriving alongside start is silently ignored.
      state_d        = ST_ACCUM;
      q_d            = '0;
      qm_d           = '1;
      result_valid_d = 1'b0;
      digit_cnt_d    = '0;
      digit_drop_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (digit_valid) begin
            digit_drop_d = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (digit_valid) begin
            q_d         = q_step;
            qm_d        = qm_step;
            digit_cnt_d = digit_cnt_q + CNT_WIDTH'(1);
            if (digit_cnt_q == LAST_CNT) begin
              result_d       = q_step;
              result_valid_d = 1'b1;
              state_d        = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (digit_valid) begin
            digit_drop_d = 1'b1;
          end
          if (result_ack) begin
            result_valid_d = 1'b0;
            state_d        = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q        <= ST_IDLE;
      q_q            <= '0;
      qm_q           <= '1;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      digit_cnt_q    <= '0;
      digit_drop_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_q            <= q_d;
      qm_q           <= qm_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      digit_cnt_q    <= digit_cnt_d;
      digit_drop_q   <= digit_drop_d;
    end
  end

`ifdef OTF_ERR_EN
  // Sticky illegal-code flag; cleared only by start or reset.
  logic digit_err_q, digit_err_d;

  always_comb begin
    digit_err_d = digit_err_q;
    if (start) begin
      digit_err_d = 1'b0;
    end else if (digit_accept && (digit_in == 2'b11)) begin
      digit_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      digit_err_q <= 1'b0;
    end else begin
      digit_err_q <= digit_err_d;
    end
  end

  assign digit_err = digit_err_q;
`else
  logic unused_accept;
  assign unused_accept = digit_accept;
  assign digit_err     = 1'b0;
`endif

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q == ST_ACCUM);
  assign digit_cnt    = digit_cnt_q;
  assign digit_drop   = digit_drop_q;

endmodule

// File: tb/tb_otf_quotient_converter.sv
// Directed bench for otf_quotient_converter: a UNROLLING=4 instance for the
// digit-pattern cases and a default UNROLLING=64 instance for the long case.
// Both share reset, digits and ack; each has its own start.

module tb_otf_quotient_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        asyn_reset  = 1'b1;
  logic        start4      = 1'b0;
  logic        start64     = 1'b0;
  logic [1:0]  digit_in    = 2'b00;
  logic        digit_valid = 1'b0;
  logic        result_ack  = 1'b0;

  logic [4:0]  result4;
  logic        rv4, busy4, drop4, err4;
  logic [10:0] cnt4;

  logic [64:0] result64;
  logic        rv64, busy64, drop64, err64;
  logic [10:0] cnt64;

  otf_quotient_converter #(.UNROLLING(4), .CNT_WIDTH(11)) u_dut4 (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .start        (start4),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .result_ack   (result_ack),
    .result       (result4),
    .result_valid (rv4),
    .busy         (busy4),
    .digit_cnt    (cnt4),
    .digit_drop   (drop4),
    .digit_err    (err4)
  );

  otf_quotient_converter u_dut64 (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .start        (start64),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .result_ack   (result_ack),
    .result       (result64),
    .result_valid (rv64),
    .busy         (busy64),
    .digit_cnt    (cnt64),
    .digit_drop   (drop64),
    .digit_err    (err64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] DP = 2'b10;
  localparam logic [1:0] DM = 2'b01;
  localparam logic [1:0] DZ = 2'b00;
  localparam logic [1:0] DX = 2'b11;

`ifdef OTF_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic send(input logic [1:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    digit_in    = DZ;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic do_reset();
    asyn_reset = 1'b1;
    tick();
    asyn_reset = 1'b0;
  endtask

  task automatic check_reset_state4(input string tag);
    check({tag, "_result"}, 65'(result4), 65'd0);
    check({tag, "_rv"},     65'(rv4),     65'd0);
    check({tag, "_busy"},   65'(busy4),   65'd0);
    check({tag, "_cnt"},    65'(cnt4),    65'd0);
    check({tag, "_drop"},   65'(drop4),   65'd0);
    check({tag, "_err"},    65'(err4),    65'd0);
  endtask

  initial begin
    tick();
    do_reset();

    // Reset values
    check_reset_state4("rst");
    check("rst_result64", result64, 65'd0);
    check("rst_rv64", 65'(rv64), 65'd0);

    // +1,0,-1,+1 back to back -> 8-2+1 = 7
    pulse_start4();
    check("t1_busy", 65'(busy4), 65'd1);
    send(DP); send(DZ); send(DM);
    check("t1_rv_before_last", 65'(rv4), 65'd0);
    check("t1_cnt3", 65'(cnt4), 65'd3);
    send(DP);
    check("t1_rv", 65'(rv4), 65'd1);
    check("t1_result", 65'(result4), 65'b00111);
    check("t1_cnt", 65'(cnt4), 65'd4);
    check("t1_busy_done", 65'(busy4), 65'd0);
    ack();
    check("t1_rv_after_ack", 65'(rv4), 65'd0);

    // -1 x4 with 2-cycle gaps -> -15 = 5'b10001
    pulse_start4();
    for (int i = 0; i < 4; i++) begin
      send(DM);
      if (i < 3) begin
        tick();
        check($sformatf("t2_busy_gap%0d", i), 65'(busy4), 65'd1);
        tick();
        check($sformatf("t2_cnt_gap%0d", i), 65'(cnt4), 65'(i + 1));
      end
    end
    check("t2_rv", 65'(rv4), 65'd1);
    check("t2_result", 65'(result4), 65'b10001);
    ack();

    // UNROLLING=64: 64 zero digits -> 0, held for 10 cycles without ack
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (int i = 0; i < 63; i++) send(DZ);
    check("t3_rv_before_last", 65'(rv64), 65'd0);
    check("t3_cnt63", 65'(cnt64), 65'd63);
    send(DZ);
    check("t3_rv", 65'(rv64), 65'd1);
    check("t3_cnt", 65'(cnt64), 65'd64);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_hold_rv%0d", i), 65'(rv64), 65'd1);
      check($sformatf("t3_hold_res%0d", i), result64, 65'd0);
    end
    ack();
    check("t3_rv_after_ack", 65'(rv64), 65'd0);
    check("t3_busy_after_ack", 65'(busy64), 65'd0);

    // Reset mid-conversion, then +1 x4 -> 15
    pulse_start4();
    send(DP); send(DP);
    do_reset();
    check_reset_state4("t4_rst");
    pulse_start4();
    for (int i = 0; i < 4; i++) send(DP);
    check("t4_rv", 65'(rv4), 65'd1);
    check("t4_result", 65'(result4), 65'd15);
    ack();

    // Digit in IDLE sets drop; start clears it
    send(DP);
    check("t5_idle_drop", 65'(drop4), 65'd1);
    check("t5_idle_cnt", 65'(cnt4), 65'd4);
    pulse_start4();
    check("t5_drop_cleared", 65'(drop4), 65'd0);
    check("t5_cnt_cleared", 65'(cnt4), 65'd0);

    // start together with a digit: digit discarded, not counted, no drop
    start4      = 1'b1;
    digit_in    = DP;
    digit_valid = 1'b1;
    tick();
    start4      = 1'b0;
    digit_valid = 1'b0;
    digit_in    = DZ;
    check("t5_start_dig_cnt", 65'(cnt4), 65'd0);
    check("t5_start_dig_drop", 65'(drop4), 65'd0);
    send(DP); send(DZ); send(DZ); send(DZ);
    check("t5_result", 65'(result4), 65'd8);

    // Digit in DONE: dropped, result held
    send(DM);
    check("t6_done_drop", 65'(drop4), 65'd1);
    check("t6_done_result", 65'(result4), 65'd8);
    check("t6_done_rv", 65'(rv4), 65'd1);

    // start in DONE discards the result; ack in ACCUM does nothing
    pulse_start4();
    check("t6_restart_rv", 65'(rv4), 65'd0);
    check("t6_restart_busy", 65'(busy4), 65'd1);
    ack();
    check("t6_ack_accum_busy", 65'(busy4), 65'd1);

    // Illegal code mid-stream, then restart in ACCUM
    send(DP); send(DX);
    check("t7_err_partial", 65'(err4), 65'(ERR_EXP));
    check("t7_cnt_partial", 65'(cnt4), 65'd2);
    pulse_start4();
    check("t7_restart_cnt", 65'(cnt4), 65'd0);
    check("t7_restart_err", 65'(err4), 65'd0);

    // +1, 11, 0, 0 -> 8, illegal code converted as zero
    send(DP); send(DX); send(DZ); send(DZ);
    check("t7_rv", 65'(rv4), 65'd1);
    check("t7_result", 65'(result4), 65'd8);
    check("t7_err", 65'(err4), 65'(ERR_EXP));
    ack();
    check("t7_rv_after_ack", 65'(rv4), 65'd0);
    check("t7_err_sticky", 65'(err4), 65'(ERR_EXP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
